// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared type definitions for the single-issue MIPS core.
//   - opcode_t / funct_t : MIPS primary opcode and R-type function fields.
//   - aluop_t            : ALU operation select.
//   - mc_state_t         : multicycle control state machine states.
//   - instr_class_t      : coarse instruction class used to sequence the FSM.
//   - pcsrc_t / immsel_t / regdst_t : datapath mux encodings.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  // MIPS primary opcodes (instr[31:26]).
  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    ADDIU = 6'b001001,
    SLTI  = 6'b001010,
    SLTIU = 6'b001011,
    ANDI  = 6'b001100,
    ORI   = 6'b001101,
    XORI  = 6'b001110,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    SW    = 6'b101011,
    HALT  = 6'b111111
  } opcode_t;

  // R-type function codes (instr[5:0]).
  typedef enum logic [5:0] {
    SLL  = 6'b000000,
    SRL  = 6'b000010,
    JR   = 6'b001000,
    ADD  = 6'b100000,
    ADDU = 6'b100001,
    SUB  = 6'b100010,
    SUBU = 6'b100011,
    AND  = 6'b100100,
    OR   = 6'b100101,
    XOR  = 6'b100110,
    NOR  = 6'b100111,
    SLT  = 6'b101010,
    SLTU = 6'b101011
  } funct_t;

  // ALU operation select.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Multicycle control states.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } mc_state_t;

  // Instruction class: decides the path taken out of EXEC.
  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ALU  = 4'd1,
    CLS_LW   = 4'd2,
    CLS_SW   = 4'd3,
    CLS_BEQ  = 4'd4,
    CLS_BNE  = 4'd5,
    CLS_J    = 4'd6,
    CLS_JR   = 4'd7,
    CLS_JAL  = 4'd8,
    CLS_HALT = 4'd9
  } instr_class_t;

  // Next-PC select.
  typedef logic [2:0] pcsrc_t;
  localparam pcsrc_t PCSRC_PC4    = 3'b000;
  localparam pcsrc_t PCSRC_RS     = 3'b001;
  localparam pcsrc_t PCSRC_JUMP   = 3'b010;
  localparam pcsrc_t PCSRC_BRANCH = 3'b101;

  // Immediate select for the ALU B operand.
  typedef logic [2:0] immsel_t;
  localparam immsel_t IMM_NONE  = 3'b000;
  localparam immsel_t IMM_SEXT  = 3'b001;
  localparam immsel_t IMM_ZEXT  = 3'b010;
  localparam immsel_t IMM_LUI   = 3'b011;
  localparam immsel_t IMM_SHAMT = 3'b100;

  // Register file write-address select.
  typedef logic [1:0] regdst_t;
  localparam regdst_t REGDST_RT = 2'b00;
  localparam regdst_t REGDST_RD = 2'b01;
  localparam regdst_t REGDST_RA = 2'b10;

endpackage

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   Purely combinational decode of the registered instruction. Produces the
//   instruction class plus the datapath controls; the FSM decides in which
//   state each of them is actually driven.
//   Ports:
//     op, funct   in   opcode (instr[31:26]) and function (instr[5:0]) fields
//     cls         out  instruction class
//     alu_op      out  ALU operation
//     alu_src     out  ALU B operand from immediate
//     src_sel     out  immediate select
//     reg_dst     out  write register select
//     mem_to_reg  out  writeback from data memory
// -----------------------------------------------------------------------------
module instr_decode
  import cpu_types_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output aluop_t       alu_op,
  output logic         alu_src,
  output immsel_t      src_sel,
  output regdst_t      reg_dst,
  output logic         mem_to_reg
);

  // Opcode / funct decode; anything unrecognised stays a NOP.
  always_comb begin
    cls        = CLS_NOP;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    src_sel    = IMM_NONE;
    reg_dst    = REGDST_RT;
    mem_to_reg = 1'b0;
    case (op)
      RTYPE: begin
        reg_dst = REGDST_RD;
        cls     = CLS_ALU;
        case (funct)
          SLL:  begin alu_op = ALU_SLL; alu_src = 1'b1; src_sel = IMM_SHAMT; end
          SRL:  begin alu_op = ALU_SRL; alu_src = 1'b1; src_sel = IMM_SHAMT; end
          ADD,
          ADDU: alu_op = ALU_ADD;
          SUB,
          SUBU: alu_op = ALU_SUB;
          AND:  alu_op = ALU_AND;
          OR:   alu_op = ALU_OR;
          XOR:  alu_op = ALU_XOR;
          NOR:  alu_op = ALU_NOR;
          SLT:  alu_op = ALU_SLT;
          SLTU: alu_op = ALU_SLTU;
          JR:   cls = CLS_JR;
          default: cls = CLS_NOP;
        endcase
      end
      ADDI,
      ADDIU: begin cls = CLS_ALU; alu_op = ALU_ADD; alu_src = 1'b1; src_sel = IMM_SEXT; end
      SLTI:  begin cls = CLS_ALU; alu_op = ALU_SLT; alu_src = 1'b1; src_sel = IMM_SEXT; end
      // Sign-extended immediate compared as unsigned (MIPS semantics).
      SLTIU: begin cls = CLS_ALU; alu_op = ALU_SLTU; alu_src = 1'b1; src_sel = IMM_SEXT; end
      ANDI:  begin cls = CLS_ALU; alu_op = ALU_AND; alu_src = 1'b1; src_sel = IMM_ZEXT; end
      ORI:   begin cls = CLS_ALU; alu_op = ALU_OR;  alu_src = 1'b1; src_sel = IMM_ZEXT; end
      XORI:  begin cls = CLS_ALU; alu_op = ALU_XOR; alu_src = 1'b1; src_sel = IMM_ZEXT; end
      // LUI: the immediate mux already shifts it up; OR with rs ($0) passes it.
      LUI:   begin cls = CLS_ALU; alu_op = ALU_OR;  alu_src = 1'b1; src_sel = IMM_LUI; end
      LW: begin
        cls        = CLS_LW;
        alu_op     = ALU_ADD;
        alu_src    = 1'b1;
        src_sel    = IMM_SEXT;
        mem_to_reg = 1'b1;
      end
      SW:    begin cls = CLS_SW; alu_op = ALU_ADD; alu_src = 1'b1; src_sel = IMM_SEXT; end
      BEQ:   begin cls = CLS_BEQ; alu_op = ALU_SUB; end
      BNE:   begin cls = CLS_BNE; alu_op = ALU_SUB; end
      J:     cls = CLS_J;
      JAL:   begin cls = CLS_JAL; reg_dst = REGDST_RA; end
      HALT:  cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Control path of the multicycle MIPS core. Holds the instruction register
//   and sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB), waiting on the
//   instruction/data memory handshakes. An optional wait timeout in FETCH/MEM
//   halts the core with fault set; retired counts completed instructions.
//   Ports:
//     CLK, RST           clock (rising edge), asynchronous active-high reset
//     imemload, ihit     instruction word and fetch-complete strobe
//     dhit               data access complete
//     zero               ALU zero flag (used in EXEC for branches)
//     iREN, dREN, dWEN   memory requests
//     instr              registered instruction
//     PCWrite, PCSrc     PC load enable and next-PC select
//     ALUop, ALUSrc, src_sel        ALU controls (EXEC only)
//     RegDst, MemtoReg, RWEN        writeback controls (WB only)
//     halt, fault, retired          status
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter int COUNT_W     = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WORD_W-1:0]  imemload,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               zero,
  output logic               iREN,
  output logic               dREN,
  output logic               dWEN,
  output logic [WORD_W-1:0]  instr,
  output logic               PCWrite,
  output pcsrc_t             PCSrc,
  output aluop_t             ALUop,
  output logic               ALUSrc,
  output immsel_t            src_sel,
  output regdst_t            RegDst,
  output logic               MemtoReg,
  output logic               RWEN,
  output logic               halt,
  output logic               fault,
  output logic [COUNT_W-1:0] retired
);

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int                 CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_LIMIT  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic               TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [COUNT_W-1:0] RETIRE_ONE = COUNT_W'(1);

  mc_state_t          state_q, state_d;
  logic [WORD_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   wait_cnt_inc;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               wait_expired;

  instr_class_t dec_cls;
  aluop_t       dec_alu_op;
  logic         dec_alu_src;
  immsel_t      dec_src_sel;
  regdst_t      dec_reg_dst;
  logic         dec_mem_to_reg;

  instr_decode u_decode (
    .op         (instr_q[31:26]),
    .funct      (instr_q[5:0]),
    .cls        (dec_cls),
    .alu_op     (dec_alu_op),
    .alu_src    (dec_alu_src),
    .src_sel    (dec_src_sel),
    .reg_dst    (dec_reg_dst),
    .mem_to_reg (dec_mem_to_reg)
  );

  // The timeout fires on the cycle whose miss would bring the count to the limit.
  assign wait_cnt_inc = wait_cnt_q + CNT_ONE;
  assign wait_expired = TIMEOUT_EN && (wait_cnt_inc == CNT_LIMIT);

  assign instr   = instr_q;
  assign fault   = fault_q;
  assign retired = retired_q;

  // State, instruction register, wait counter, fault flag and retire counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= FETCH;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    wait_cnt_d = '0;          // leaving FETCH/MEM clears it for the next entry
    fault_d    = fault_q;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_PC4;
    ALUop      = ALU_ADD;
    ALUSrc     = 1'b0;
    src_sel    = IMM_NONE;
    RegDst     = REGDST_RT;
    MemtoReg   = 1'b0;
    RWEN       = 1'b0;
    halt       = 1'b0;

    case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          instr_d = imemload;
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      DECODE: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_PC4;
        if (dec_cls == CLS_HALT) begin
          state_d = HALTED;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        ALUop   = dec_alu_op;
        ALUSrc  = dec_alu_src;
        src_sel = dec_src_sel;
        case (dec_cls)
          CLS_ALU: state_d = WB;
          CLS_LW,
          CLS_SW:  state_d = MEM;
          CLS_BEQ: begin
            if (zero) begin
              PCWrite = 1'b1;
              PCSrc   = PCSRC_BRANCH;
            end else begin
              PCWrite = 1'b0;
            end
            state_d = FETCH;
          end
          CLS_BNE: begin
            if (!zero) begin
              PCWrite = 1'b1;
              PCSrc   = PCSRC_BRANCH;
            end else begin
              PCWrite = 1'b0;
            end
            state_d = FETCH;
          end
          CLS_J: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
            state_d = FETCH;
          end
          CLS_JR: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_RS;
            state_d = FETCH;
          end
          CLS_JAL: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
            state_d = WB;
          end
          default: state_d = FETCH;   // NOP / unknown encoding
        endcase
      end

      MEM: begin
        dREN = (dec_cls == CLS_LW);
        dWEN = (dec_cls == CLS_SW);
        // A hit in the expiry cycle still wins.
        if (dhit) begin
          state_d = (dec_cls == CLS_LW) ? WB : FETCH;
        end else if (wait_expired) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      WB: begin
        RWEN     = 1'b1;
        RegDst   = dec_reg_dst;
        MemtoReg = dec_mem_to_reg;
        state_d  = FETCH;
      end

      HALTED: begin
        halt    = 1'b1;
        state_d = HALTED;
      end

      default: state_d = FETCH;
    endcase

    // Retire on every return to FETCH, and on the HALT opcode itself.
    if ((state_d == FETCH && state_q != FETCH) ||
        (state_q == DECODE && state_d == HALTED)) begin
      retired_d = retired_q + RETIRE_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed-vector bench for multicycle_control_unit (MEM_TIMEOUT = 4).
//   Inputs change just after the rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h0022_1820;  // add   $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C22_0004;  // lw    $2,4($1)
  localparam logic [31:0] I_SW    = 32'hAC22_0004;  // sw    $2,4($1)
  localparam logic [31:0] I_BEQ   = 32'h1022_0002;  // beq   $1,$2,+2
  localparam logic [31:0] I_BNE   = 32'h1422_0002;  // bne   $1,$2,+2
  localparam logic [31:0] I_SLTIU = 32'h2C22_FFFF;  // sltiu $2,$1,0xFFFF
  localparam logic [31:0] I_JAL   = 32'h0C00_0040;  // jal   0x100
  localparam logic [31:0] I_UNK   = 32'hF800_0000;  // undefined opcode
  localparam logic [31:0] I_HALT  = 32'hFC00_0000;  // halt

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] imemload = 32'h0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        zero = 1'b0;
  logic        iREN, dREN, dWEN, PCWrite, ALUSrc, MemtoReg, RWEN, halt, fault;
  logic [31:0] instr;
  logic [31:0] retired;
  pcsrc_t      PCSrc;
  aluop_t      ALUop;
  immsel_t     src_sel;
  regdst_t     RegDst;

  int n_vec = 0;
  int n_err = 0;
  int dren_cnt;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(
    .WORD_W      (32),
    .MEM_TIMEOUT (4),
    .COUNT_W     (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemload (imemload),
    .ihit     (ihit),
    .dhit     (dhit),
    .zero     (zero),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .instr    (instr),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .ALUop    (ALUop),
    .ALUSrc   (ALUSrc),
    .src_sel  (src_sel),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RWEN     (RWEN),
    .halt     (halt),
    .fault    (fault),
    .retired  (retired)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench at the start of cycle 1 (FETCH) with all inputs idle.
  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; imemload = 32'h0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
  endtask

  // FETCH with immediate ihit, then DECODE; returns at the start of EXEC.
  task automatic fetch_decode(input string tag, input logic [31:0] w);
    imemload = w; ihit = 1'b1;
    #1;
    check_vec({tag, "_fetch_iren"}, 32'(iREN), 32'd1);
    tick();
    ihit = 1'b0; imemload = 32'h0;
    #1;
    check_vec({tag, "_dec_pcwrite"}, 32'(PCWrite), 32'd1);
    check_vec({tag, "_dec_instr"}, instr, w);
    tick();
  endtask

  initial begin
    do_reset();
    // Reset state, cycle 1 idle FETCH.
    check_vec("rst_iren", 32'(iREN), 32'd1);
    check_vec("rst_instr", instr, 32'h0);
    check_vec("rst_retired", retired, 32'd0);
    check_vec("rst_halt", 32'(halt), 32'd0);
    check_vec("rst_fault", 32'(fault), 32'd0);
    check_vec("rst_dren", 32'(dREN | dWEN), 32'd0);

    // ADD: FETCH, DECODE, EXEC, WB(cycle 4), retired=1 in cycle 5.
    do_reset();
    fetch_decode("add", I_ADD);
    #1;
    check_vec("add_exec_aluop", 32'(ALUop), 32'(ALU_ADD));
    check_vec("add_exec_alusrc", 32'(ALUSrc), 32'd0);
    check_vec("add_exec_rwen", 32'(RWEN), 32'd0);
    tick(); #1;
    check_vec("add_wb_rwen", 32'(RWEN), 32'd1);
    check_vec("add_wb_regdst", 32'(RegDst), 32'(REGDST_RD));
    tick(); #1;
    check_vec("add_retired", retired, 32'd1);
    check_vec("add_next_fetch", 32'(iREN), 32'd1);

    // LW with dhit in the 4th MEM cycle (also the timeout boundary: hit wins).
    fetch_decode("lw", I_LW);
    #1;
    check_vec("lw_exec_srcsel", 32'(src_sel), 32'(IMM_SEXT));
    check_vec("lw_exec_alusrc", 32'(ALUSrc), 32'd1);
    tick();
    dren_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      dren_cnt += int'(dREN);
      check_vec($sformatf("lw_mem%0d_no_iren", i), 32'(iREN), 32'd0);
      tick();
      dhit = 1'b0;
    end
    #1;
    dren_cnt += int'(dREN);
    check_vec("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
    check_vec("lw_wb_rwen", 32'(RWEN), 32'd1);
    check_vec("lw_wb_fault", 32'(fault), 32'd0);
    check_vec("lw_dren_cycles", 32'(dren_cnt), 32'd4);
    tick(); #1;
    check_vec("lw_retired", retired, 32'd2);

    // BEQ taken, then BNE not taken (zero=1 for both).
    fetch_decode("beq", I_BEQ);
    zero = 1'b1; #1;
    check_vec("beq_exec_pcwrite", 32'(PCWrite), 32'd1);
    check_vec("beq_exec_pcsrc", 32'(PCSrc), 32'(PCSRC_BRANCH));
    tick(); zero = 1'b0;
    fetch_decode("bne", I_BNE);
    zero = 1'b1; #1;
    check_vec("bne_exec_pcwrite", 32'(PCWrite), 32'd0);
    tick(); zero = 1'b0; #1;
    check_vec("bne_next_fetch", 32'(iREN), 32'd1);
    check_vec("bne_retired", retired, 32'd4);

    // SLTIU: unsigned compare with sign-extended immediate.
    fetch_decode("sltiu", I_SLTIU);
    #1;
    check_vec("sltiu_aluop", 32'(ALUop), 32'(ALU_SLTU));
    check_vec("sltiu_srcsel", 32'(src_sel), 32'(IMM_SEXT));
    tick(); #1;
    check_vec("sltiu_wb_regdst", 32'(RegDst), 32'(REGDST_RT));

    // JAL: jump in EXEC, write $31 in WB.
    tick();
    fetch_decode("jal", I_JAL);
    #1;
    check_vec("jal_exec_pcsrc", 32'(PCSrc), 32'(PCSRC_JUMP));
    check_vec("jal_exec_pcwrite", 32'(PCWrite), 32'd1);
    tick(); #1;
    check_vec("jal_wb_rwen", 32'(RWEN), 32'd1);
    check_vec("jal_wb_regdst", 32'(RegDst), 32'(REGDST_RA));

    // SW with immediate dhit: 4 cycles, no writeback.
    tick();
    fetch_decode("sw", I_SW);
    tick();
    dhit = 1'b1; #1;
    check_vec("sw_mem_dwen", 32'(dWEN), 32'd1);
    check_vec("sw_mem_dren", 32'(dREN), 32'd0);
    tick(); dhit = 1'b0; #1;
    check_vec("sw_next_fetch", 32'(iREN), 32'd1);
    check_vec("sw_retired", retired, 32'd7);

    // Unknown opcode behaves as NOP: EXEC straight back to FETCH.
    fetch_decode("unk", I_UNK);
    #1;
    check_vec("unk_exec_pcwrite", 32'(PCWrite), 32'd0);
    tick(); #1;
    check_vec("unk_next_fetch", 32'(iREN), 32'd1);
    check_vec("unk_retired", retired, 32'd8);

    // HALT: halted from cycle 3, retired +1, stays inert even with ihit.
    fetch_decode("halt", I_HALT);
    ihit = 1'b1; #1;
    check_vec("halt_c3_halt", 32'(halt), 32'd1);
    check_vec("halt_c3_retired", retired, 32'd9);
    check_vec("halt_c3_fault", 32'(fault), 32'd0);
    tick(); #1;
    check_vec("halt_c4_halt", 32'(halt), 32'd1);
    check_vec("halt_c4_iren", 32'(iREN), 32'd0);
    check_vec("halt_c4_pcwrite", 32'(PCWrite), 32'd0);
    check_vec("halt_c4_retired", retired, 32'd9);
    ihit = 1'b0;

    // Timeout: no ihit for 4 FETCH cycles -> halted with fault.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("to_fetch%0d_halt", i), 32'(halt), 32'd0);
      tick();
    end
    #1;
    check_vec("to_halt", 32'(halt), 32'd1);
    check_vec("to_fault", 32'(fault), 32'd1);
    check_vec("to_iren", 32'(iREN), 32'd0);
    check_vec("to_retired", retired, 32'd0);

    // Timeout boundary: ihit in the 4th FETCH cycle advances normally.
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    imemload = I_ADD; ihit = 1'b1;
    tick();
    ihit = 1'b0; #1;
    check_vec("tob_decode_pcwrite", 32'(PCWrite), 32'd1);
    check_vec("tob_fault", 32'(fault), 32'd0);
    check_vec("tob_halt", 32'(halt), 32'd0);

    // RST asserted mid-WB: outputs drop immediately.
    tick(); tick(); #1;
    check_vec("rstwb_rwen_before", 32'(RWEN), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    check_vec("rstwb_rwen", 32'(RWEN), 32'd0);
    check_vec("rstwb_instr", instr, 32'h0);
    check_vec("rstwb_iren", 32'(iREN), 32'd1);
    check_vec("rstwb_regdst", 32'(RegDst), 32'(REGDST_RT));
    #1;
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multicycle control path for the single-issue MIPS core.
- Holds the instruction register and a state machine that sequences FETCH, DECODE, EXEC, MEM and WB.
- Waits on instruction/data memory handshakes and drives per-state datapath enables.
- Adds a configurable memory-wait timeout, corrected unsigned-compare decode, and a retired-instruction counter.

## Interface
- WORD_W, 32: instruction/data word width.
- MEM_TIMEOUT, 0: max wait cycles in FETCH or MEM; 0 disables the timeout.
- COUNT_W, 32: width of the retired-instruction counter.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemload  in  WORD_W  instruction word; valid when ihit=1.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- zero  in  1  ALU zero flag, valid in EXEC.
- iREN  out  1  instruction read request.
- dREN, dWEN  out  1 each  data read/write request.
- instr  out  WORD_W  registered instruction.
- PCWrite  out  1  PC load enable.
- PCSrc  out  3  next-PC select: 000 pc+4, 001 rs (JR), 010 jump target, 101 branch target.
- ALUop  out  aluop_t  ALU operation.
- ALUSrc  out  1  ALU B operand from immediate.
- src_sel  out  3  immediate select: 001 signext, 010 zeroext, 011 lui, 100 shamt.
- RegDst  out  2  write register: 00 rt, 01 rd, 10 $31.
- MemtoReg  out  1  writeback from data memory.
- RWEN  out  1  register file write enable.
- halt  out  1  core halted; sticky.
- fault  out  1  halt caused by timeout; sticky.
- retired  out  COUNT_W  retired instruction count.

## Operation
- State machine states:
  - FETCH: iREN=1. On ihit, capture imemload into instr and go to DECODE.
  - DECODE: PCWrite=1, PCSrc=000. HALT opcode goes to HALTED; all other opcodes go to EXEC.
  - EXEC: drive ALUop/ALUSrc/src_sel. Next state by instruction class:
    - R-type/I-type ALU: go to WB.
    - LW/SW: go to MEM.
    - BEQ/BNE: if the branch is taken (zero for BEQ, !zero for BNE), PCWrite=1, PCSrc=101. Go to FETCH.
    - J: PCWrite=1, PCSrc=010. Go to FETCH.
    - JR: PCWrite=1, PCSrc=001. Go to FETCH.
    - JAL: PCWrite=1, PCSrc=010. Go to WB with RegDst=10.
  - MEM: dREN=1 for LW, dWEN=1 for SW; held until dhit. On dhit, LW goes to WB and SW goes to FETCH.
  - WB: RWEN=1 for exactly one cycle. MemtoReg=1 for LW. Go to FETCH.
  - HALTED: halt=1, all enables 0. Exited only by RST.
- Decode rules:
  - SLL/SRL use shamt (src_sel=100).
  - ADDI/ADDIU/SLTI/LW/SW use signext.
  - SLTIU uses signext with ALU_SLTU.
  - ANDI/ORI/XORI use zeroext.
  - LUI uses ALU_OR with src_sel=011.
- Unknown opcode or funct: treated as a NOP; EXEC goes straight to FETCH.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and increments each cycle with no hit.
  - When the counter reaches MEM_TIMEOUT with no hit, go to HALTED with fault=1.
  - Counter width is $clog2(MEM_TIMEOUT+1).
- retired increments on every exit to FETCH and on entry to HALTED via the HALT opcode. It wraps modulo 2^COUNT_W.
- A hit arriving in the same cycle the timeout is reached wins: normal advance, no fault.

## Timing
- Reset values: state=FETCH, instr=0, retired=0, timeout counter=0, halt=0, fault=0.
- All Moore outputs are decoded from the state and registered instr.
- Exception: in FETCH/MEM, the advance happens in the hit cycle.
- Zero-wait cycle counts:
  - R-type/I-type: 4 (FETCH, DECODE, EXEC, WB).
  - LW: 5.
  - SW: 4.
  - Branch/J/JR: 3.
  - JAL: 4.
- Each wait cycle adds 1.
- RST mid-MEM: dREN/dWEN drop asynchronously; instr clears.
- iREN and dREN/dWEN are never asserted in the same cycle.

## Structure
- cpu_types_pkg gains:
  - mc_state_t enum (FETCH, DECODE, EXEC, MEM, WB, HALTED).
  - pcsrc_t, immsel_t and regdst_t localparam encodings.
- The existing opcode, funct and aluop_t definitions are reused unchanged.
- Sub-module instr_decode: purely combinational. Maps instr to an instruction class plus ALUop/ALUSrc/src_sel/RegDst/MemtoReg. The FSM gates these per state.

## Test plan
- ADD $3,$1,$2 with ihit on first FETCH cycle: RWEN=1 with RegDst=01 in cycle 4; retired=1 in cycle 5.
- LW with dhit delayed 3 cycles: MEM lasts 4 cycles; MemtoReg=1 and RWEN=1 in cycle 8; dREN high exactly 4 cycles.
- BEQ with zero=1, then BNE with zero=1: first gives PCWrite=1 and PCSrc=101 in EXEC; second gives only the DECODE PCWrite.
- SLTIU 0xFFFF: ALUop=ALU_SLTU, src_sel=001. JAL: RegDst=10 and RWEN=1 in WB.
- MEM_TIMEOUT=4, ihit never asserted: halt=1 and fault=1 after 4 FETCH cycles. With ihit in the 4th cycle: DECODE, fault=0.
- HALT opcode: halt=1 from cycle 3 onward and retired increments once. RST asserted mid-WB: all outputs return to reset values immediately.
